// File: rtl/mask_bound_decode_32bit.sv
// -----------------------------------------------------------------------------
// mask_bound_decode_32bit
//
// Purpose:
//   Inverse of the 32-bit thermometer mask generator. Recovers the bound index
//   from a stored bound mask. The index is the length of the contiguous run of
//   ones, counted either from bit 31 downwards (left) or from bit 0 upwards
//   (right). The search takes five binary steps of width 16, 8, 4, 2 and 1. It
//   uses the same level trig / done handshake as the mask generator.
//
// Ports:
//   i_clk            in   1   clock, rising edge
//   i_rst            in   1   synchronous reset, active-high
//   i_trig           in   1   start request (level), hold high until o_done
//   i_left_or_right  in   1   0 = count ones from bit 31 down,
//                             1 = count ones from bit 0 up
//   i_mask           in   32  mask to decode, sampled only on the accept edge
//   o_done           out  1   result valid
//   o_index          out  5   decoded run length 0..31 (saturates at 31)
//   o_full           out  1   mask was all ones (true length 32)
//   o_err            out  1   mask is not a clean thermometer
//
// Optional feature macro: MASK_CHECK_EN
//   defined   -> o_err reports any one bit lying beyond the terminating zero
//   undefined -> no check logic is built and o_err is tied to 0
// -----------------------------------------------------------------------------
module mask_bound_decode_32bit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trig,
    input  logic        i_left_or_right,
    input  logic [31:0] i_mask,
    output logic        o_done,
    output logic [4:0]  o_index,
    output logic        o_full,
    output logic        o_err
);

    localparam int WIDTH = 32;
    localparam int IDX_W = 5;
    localparam int NSTEP = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP1 = 3'd1,
        STEP2 = 3'd2,
        STEP3 = 3'd3,
        STEP4 = 3'd4,
        STEP5 = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   w_reg;      // working copy, consumed run shifted out
    logic [IDX_W-1:0]   c_reg;      // ones counted so far
    logic               dir_reg;    // latched direction
    logic               full_reg;   // latched "mask was all ones"

    // Pre-compute the "all ones" test for every step width. Step k examines
    // the s = 16 >> k outermost bits on the counting side of the work reg.
    logic [NSTEP-1:0]   left_ones;
    logic [NSTEP-1:0]   right_ones;

    genvar gi;
    generate
        for (gi = 0; gi < NSTEP; gi++) begin : g_step
            localparam int S = (WIDTH / 2) >> gi;
            assign left_ones[gi]  = &w_reg[WIDTH-1 -: S];
            assign right_ones[gi] = &w_reg[S-1:0];
        end
    endgenerate

    // Step-state datapath: select the width for the current step and form
    // the next count and work values when that slice is all ones.
    logic [2:0]         step_k;
    logic               step_hit;
    logic [IDX_W-1:0]   step_size;
    logic [IDX_W-1:0]   c_next;
    logic [WIDTH-1:0]   w_next;

    always_comb begin
        step_k    = 3'd0;
        step_hit  = 1'b0;
        step_size = '0;
        c_next    = c_reg;
        w_next    = w_reg;
        case (state_reg)
            STEP1:   step_k = 3'd0;
            STEP2:   step_k = 3'd1;
            STEP3:   step_k = 3'd2;
            STEP4:   step_k = 3'd3;
            STEP5:   step_k = 3'd4;
            default: step_k = 3'd0;
        endcase
        step_size = IDX_W'((WIDTH / 2) >> step_k);
        step_hit  = dir_reg ? right_ones[step_k] : left_ones[step_k];
        if (step_hit) begin
            // The counts add up to at most 31, so c never wraps.
            c_next = c_reg + step_size;
            w_next = dir_reg ? (w_reg >> step_size) : (w_reg << step_size);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            w_reg     <= '0;
            c_reg     <= '0;
            dir_reg   <= 1'b0;
            full_reg  <= 1'b0;
            o_done    <= 1'b0;
            o_index   <= '0;
            o_full    <= 1'b0;
        end else begin
            // Outputs are registered from the current state. This puts one
            // edge between entering DONE and o_done rising, and one edge
            // between leaving DONE and o_done falling.
            o_done  <= (state_reg == DONE);
            o_index <= (state_reg == DONE) ? c_reg : '0;
            o_full  <= (state_reg == DONE) ? full_reg : 1'b0;

            case (state_reg)
                IDLE: begin
                    if (i_trig) begin
                        w_reg     <= i_mask;
                        dir_reg   <= i_left_or_right;
                        c_reg     <= '0;
                        full_reg  <= (i_mask == {WIDTH{1'b1}});
                        state_reg <= STEP1;
                    end
                end
                STEP1: begin
                    c_reg     <= c_next;
                    w_reg     <= w_next;
                    state_reg <= STEP2;
                end
                STEP2: begin
                    c_reg     <= c_next;
                    w_reg     <= w_next;
                    state_reg <= STEP3;
                end
                STEP3: begin
                    c_reg     <= c_next;
                    w_reg     <= w_next;
                    state_reg <= STEP4;
                end
                STEP4: begin
                    c_reg     <= c_next;
                    w_reg     <= w_next;
                    state_reg <= STEP5;
                end
                STEP5: begin
                    c_reg     <= c_next;
                    w_reg     <= w_next;
                    state_reg <= DONE;
                end
                DONE: begin
                    // Hold the result for as long as the requester keeps
                    // trig high. A new search starts only from IDLE.
                    if (!i_trig) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef MASK_CHECK_EN
    // After the search, the terminating zero sits at the counting edge of
    // w_reg. Any remaining one bit means the mask was not a thermometer.
    // An all-ones mask leaves a single one behind (c saturates at 31), so
    // the full flag masks that case out.
    logic err_value;
    assign err_value = ~full_reg & (|w_reg);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else begin
            o_err <= (state_reg == DONE) ? err_value : 1'b0;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mask_bound_decode_32bit.sv
// -----------------------------------------------------------------------------
// tb_mask_bound_decode_32bit
//
// Runs directed cases and random cases through the decoder. Each result is
// compared against a reference model. The model counts the run of ones bit by
// bit and rebuilds the ideal thermometer mask to judge the error flag.
// -----------------------------------------------------------------------------
module tb_mask_bound_decode_32bit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_trig = 1'b0;
    logic        i_left_or_right = 1'b0;
    logic [31:0] i_mask = '0;
    logic        o_done;
    logic [4:0]  o_index;
    logic        o_full;
    logic        o_err;

    int tests = 0;
    int fails = 0;

    mask_bound_decode_32bit dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_trig          (i_trig),
        .i_left_or_right (i_left_or_right),
        .i_mask          (i_mask),
        .o_done          (o_done),
        .o_index         (o_index),
        .o_full          (o_full),
        .o_err           (o_err)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    function automatic int model_len(input logic [31:0] m, input logic dir);
        int n = 0;
        if (dir == 1'b0) begin
            while (n < 32 && m[31 - n]) n++;
        end else begin
            while (n < 32 && m[n]) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] model_therm(input int n, input logic dir);
        logic [31:0] t = '0;
        for (int i = 0; i < n; i++) begin
            if (dir == 1'b0) t[31 - i] = 1'b1;
            else             t[i]      = 1'b1;
        end
        return t;
    endfunction

    function automatic logic [4:0] model_index(input logic [31:0] m, input logic dir);
        int n = model_len(m, dir);
        return (n >= 32) ? 5'd31 : n[4:0];
    endfunction

    function automatic logic model_full(input logic [31:0] m);
        return (m == 32'hFFFF_FFFF);
    endfunction

    function automatic logic model_err(input logic [31:0] m, input logic dir);
`ifdef MASK_CHECK_EN
        return (m != model_therm(model_len(m, dir), dir));
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the result after the accept edge, then check it. The task is
    // entered just after the accept posedge.
    task automatic wait_and_check(input string tag, input logic [31:0] m, input logic dir);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_done_early"}, {31'd0, o_done}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        chk({tag, "_done"},  {31'd0, o_done}, 32'd1);
        chk({tag, "_index"}, {27'd0, o_index}, {27'd0, model_index(m, dir)});
        chk({tag, "_full"},  {31'd0, o_full},  {31'd0, model_full(m)});
        chk({tag, "_err"},   {31'd0, o_err},   {31'd0, model_err(m, dir)});
        $display("[TB] %s mask=%08h dir=%0d index=%0d full=%0d err=%0d",
                 tag, m, dir, o_index, o_full, o_err);
    endtask

    // Drop trig. o_done is still high one edge later and low after the next
    // edge. The task returns at a negedge with the DUT idle.
    task automatic release_trig(input string tag);
        i_trig = 1'b0;
        @(negedge i_clk);
        chk({tag, "_hold_after_drop"}, {31'd0, o_done}, 32'd1);
        @(negedge i_clk);
        chk({tag, "_done_fall"},  {31'd0, o_done}, 32'd0);
        chk({tag, "_index_fall"}, {27'd0, o_index}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] m, input logic dir);
        i_mask          = m;
        i_left_or_right = dir;
        i_trig          = 1'b1;
        @(posedge i_clk);                 // accept edge
        wait_and_check(tag, m, dir);
        release_trig(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rm;
        logic        rd;
        int          rn;

        // Reset
        repeat (2) @(negedge i_clk);
        chk("reset_done",  {31'd0, o_done}, 32'd0);
        chk("reset_index", {27'd0, o_index}, 32'd0);
        chk("reset_full",  {31'd0, o_full},  32'd0);
        chk("reset_err",   {31'd0, o_err},   32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Directed cases
        run("left_fff00000",  32'hFFF0_0000, 1'b0);
        run("right_0000007f", 32'h0000_007F, 1'b1);
        run("right_zero",     32'h0000_0000, 1'b1);
        run("left_zero",      32'h0000_0000, 1'b0);
        run("left_all_ones",  32'hFFFF_FFFF, 1'b0);
        run("right_all_ones", 32'hFFFF_FFFF, 1'b1);
        run("right_7fffffff", 32'h7FFF_FFFF, 1'b1);
        run("left_fffffffe",  32'hFFFF_FFFE, 1'b0);
        run("left_f0000001",  32'hF000_0001, 1'b0);
        run("left_f0000000",  32'hF000_0000, 1'b0);
        run("right_80000003", 32'h8000_0003, 1'b1);

        // Reset during STEP3, with trig held, then a fresh run
        i_mask = 32'hFFFF_F000; i_left_or_right = 1'b0; i_trig = 1'b1;
        @(posedge i_clk);                 // accept
        repeat (2) @(posedge i_clk);      // STEP1, STEP2 done -> STEP3
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_mid_done",  {31'd0, o_done}, 32'd0);
        chk("rst_mid_index", {27'd0, o_index}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);                 // accept again, trig still high
        wait_and_check("rst_restart", 32'hFFFF_F000, 1'b0);
        release_trig("rst_restart");

        // Input changes after accept are ignored, and the result is held
        i_mask = 32'hFF00_0000; i_left_or_right = 1'b0; i_trig = 1'b1;
        @(posedge i_clk);                 // accept
        @(posedge i_clk);                 // STEP1 -> STEP2
        @(negedge i_clk);
        i_mask = 32'h0000_0000;
        i_left_or_right = 1'b1;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        chk("ignore_done_early", {31'd0, o_done}, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("ignore_done",  {31'd0, o_done}, 32'd1);
        chk("ignore_index", {27'd0, o_index}, 32'd8);
        $display("[TB] ignore_change index=%0d", o_index);
        begin
            int held_ok = 1;
            for (int i = 0; i < 20; i++) begin
                @(negedge i_clk);
                if (o_done !== 1'b1 || o_index !== 5'd8) held_ok = 0;
            end
            chk("hold_20_cycles", held_ok, 1);
        end
        release_trig("ignore_change");
        run("after_hold", 32'h0000_003F, 1'b1);

        // Random cases: clean thermometers with occasional stray bits
        for (int t = 0; t < 40; t++) begin
            rd = 1'($urandom_range(0, 1));
            rn = $urandom_range(0, 32);
            rm = model_therm(rn, rd);
            if ($urandom_range(0, 2) == 0) rm = rm | $urandom();
            run($sformatf("rand%0d", t), rm, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
